// File: rtl/tick_gen.sv
// tick_gen: multi-channel timebase for the board designs.
//
// Produces NUM_CH independent single-cycle tick strobes from the system
// clock. Each channel has its own runtime-loadable divisor, count enable and
// restart. The block also produces a 50% duty display-refresh clock and a
// digit-scan index for the 7-segment multiplexer. Downstream logic uses the
// ticks as clock enables, never as clocks.
//
// Parameters:
//   NUM_CH     number of tick channels
//   CNT_W      divisor / counter width per channel
//   DIV_INIT   NUM_CH*CNT_W reset divisors, channel 0 in the LSBs
//   DISP_LOG2  disp_clk period is 2**DISP_LOG2 clock cycles
//   SCAN_W     scan_idx width
//
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous reset, active low
//   en        in   per-channel count enable
//   clr       in   per-channel synchronous restart (counter to 0)
//   div_load  in   per-channel divisor load strobe (also restarts counter)
//   div_val   in   divisor value shared by all load strobes
//   tick      out  registered one-cycle strobe per channel
//   disp_clk  out  registered 50% duty display-refresh clock
//   scan_idx  out  digit-scan index, advances once per disp_clk period
//
// Build option:
//   TICK_GEN_SYNC_EN  when defined, en and clr pass through a 2-flop
//                     synchroniser before use (2-cycle extra latency);
//                     div_load is not synchronised.

module tick_gen #(
  parameter int                        NUM_CH    = 3,
  parameter int                        CNT_W     = 32,
  parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT  = {32'd200_000_000,
                                                    32'd100_000_000,
                                                    32'd100_000},
  parameter int                        DISP_LOG2 = 20,
  parameter int                        SCAN_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    en,
  input  logic [NUM_CH-1:0]    clr,
  input  logic [NUM_CH-1:0]    div_load,
  input  logic [CNT_W-1:0]     div_val,
  output logic [NUM_CH-1:0]    tick,
  output logic                 disp_clk,
  output logic [SCAN_W-1:0]    scan_idx
);

  logic [NUM_CH-1:0]    en_use;
  logic [NUM_CH-1:0]    clr_use;

  logic [CNT_W-1:0]     cnt [NUM_CH];
  logic [CNT_W-1:0]     div [NUM_CH];

  logic [DISP_LOG2-1:0] disp_cnt;
  logic [DISP_LOG2-1:0] disp_cnt_next;

`ifdef TICK_GEN_SYNC_EN
  logic [NUM_CH-1:0]    en_s1;
  logic [NUM_CH-1:0]    en_s2;
  logic [NUM_CH-1:0]    clr_s1;
  logic [NUM_CH-1:0]    clr_s2;

  // Two-flop synchroniser for switch-driven enable and restart inputs.
  // Cleared by reset so a channel never sees a stale enable after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_s1  <= '0;
      en_s2  <= '0;
      clr_s1 <= '0;
      clr_s2 <= '0;
    end else begin
      en_s1  <= en;
      en_s2  <= en_s1;
      clr_s1 <= clr;
      clr_s2 <= clr_s1;
    end
  end

  assign en_use  = en_s2;
  assign clr_use = clr_s2;
`else
  assign en_use  = en;
  assign clr_use = clr;
`endif

  // Per-channel divider. Priority per edge is reset, load, restart, enable.
  // The counter runs 0 .. div-1 and the tick is raised on the edge that
  // sees div-1, so the period is exactly div enabled cycles. A divisor of
  // zero stalls the channel with the counter parked at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]  <= '0;
        div[i]  <= DIV_INIT[i*CNT_W +: CNT_W];
        tick[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (div_load[i]) begin
          div[i]  <= div_val;
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
        end else if (clr_use[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
        end else if (en_use[i]) begin
          if (div[i] == '0) begin
            cnt[i]  <= '0;
            tick[i] <= 1'b0;
          end else if (cnt[i] == div[i] - CNT_W'(1)) begin
            cnt[i]  <= '0;
            tick[i] <= 1'b1;
          end else begin
            cnt[i]  <= cnt[i] + CNT_W'(1);
            tick[i] <= 1'b0;
          end
        end else begin
          tick[i] <= 1'b0;
        end
      end
    end
  end

  assign disp_cnt_next = disp_cnt + DISP_LOG2'(1);

  // Free-running display timebase, independent of the channel controls.
  // disp_clk is registered from the incremented counter's MSB so it stays
  // aligned with the counter value. The scan index advances on the edge
  // where the counter wraps from all ones back to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_cnt <= '0;
      disp_clk <= 1'b0;
      scan_idx <= '0;
    end else begin
      disp_cnt <= disp_cnt_next;
      disp_clk <= disp_cnt_next[DISP_LOG2-1];
      if (&disp_cnt) begin
        scan_idx <= scan_idx + SCAN_W'(1);
      end
    end
  end

endmodule
